// File: rtl/pl_inst_decode.sv
// rtl/pl_inst_decode.sv - RV32IM-subset decode stage with registered ID/EX slot
// Decodes IF input against a combinational regfile read and interlocks on load-use.
module pl_inst_decode #(
  parameter int INST_DW  = 32,
  parameter int INST_AW  = 32,
  parameter int REG_DW   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_DW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid_i,
  output logic                if_ready_o,
  input  logic [INST_DW-1:0]  inst_i,
  input  logic [INST_AW-1:0]  pc_i,
  output logic                rs1_en_o,
  output logic [REG_AW-1:0]   rs1_addr_o,
  input  logic [REG_DW-1:0]   rs1_dout_i,
  output logic                rs2_en_o,
  output logic [REG_AW-1:0]   rs2_addr_o,
  input  logic [REG_DW-1:0]   rs2_dout_i,
  input  logic                flush_i,
  output logic                ex_valid_o,
  input  logic                ex_ready_i,
  output logic [INST_AW-1:0]  ex_pc_o,
  output logic [ALUOP_DW-1:0] alu_opcode_o,
  output logic [REG_DW-1:0]   operand_1_o,
  output logic [REG_DW-1:0]   operand_2_o,
  output logic                branch_en_o,
  output logic [INST_AW-1:0]  branch_offset_o,
  output logic                jump_en_o,
  output logic [INST_AW-1:0]  jump_offset_o,
  output logic                mem_ren_o,
  output logic                mem_wen_o,
  output logic [REG_DW-1:0]   mem_din_o,
  output logic                wb_en_o,
  output logic                wb_sel_o,
  output logic [REG_AW-1:0]   wb_addr_o,
  output logic                illegal_o
);

  localparam logic [ALUOP_DW-1:0] OP_NOP   = ALUOP_DW'(0);
  localparam logic [ALUOP_DW-1:0] OP_ADD   = ALUOP_DW'(1);
  localparam logic [ALUOP_DW-1:0] OP_MUL   = ALUOP_DW'(2);
  localparam logic [ALUOP_DW-1:0] OP_BNE   = ALUOP_DW'(3);
  localparam logic [ALUOP_DW-1:0] OP_JAL   = ALUOP_DW'(4);
  localparam logic [ALUOP_DW-1:0] OP_LUI   = ALUOP_DW'(5);
  localparam logic [ALUOP_DW-1:0] OP_AUIPC = ALUOP_DW'(6);
  localparam logic [ALUOP_DW-1:0] OP_AND   = ALUOP_DW'(7);
  localparam logic [ALUOP_DW-1:0] OP_SLL   = ALUOP_DW'(8);
  localparam logic [ALUOP_DW-1:0] OP_SLT   = ALUOP_DW'(9);
  localparam logic [ALUOP_DW-1:0] OP_BLT   = ALUOP_DW'(10);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign funct7 = inst_i[31:25];

  logic [REG_DW-1:0]  imm_i, imm_s, imm_u;
  logic [INST_AW-1:0] imm_b, imm_j;
  assign imm_i = REG_DW'($signed(inst_i[31:20]));
  assign imm_s = REG_DW'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_u = REG_DW'({inst_i[31:12], 12'b0});
  assign imm_b = INST_AW'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_j = INST_AW'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));

  logic                use_rs1, use_rs2, wr_rd, dec_illegal;
  logic [ALUOP_DW-1:0] alu_opcode_d;
  logic [REG_DW-1:0]   operand_1_d, operand_2_d, mem_din_d;
  logic                branch_en_d, jump_en_d, mem_ren_d, mem_wen_d, wb_sel_d;
  logic [INST_AW-1:0]  branch_offset_d, jump_offset_d;

  always_comb begin
    alu_opcode_d = OP_NOP;  operand_1_d = '0;     operand_2_d = '0;
    mem_din_d = '0;         branch_en_d = 1'b0;   branch_offset_d = '0;
    jump_en_d = 1'b0;       jump_offset_d = '0;   mem_ren_d = 1'b0;
    mem_wen_d = 1'b0;       wb_sel_d = 1'b0;      wr_rd = 1'b0;
    use_rs1 = 1'b0;         use_rs2 = 1'b0;       dec_illegal = 1'b0;
    case (opcode)
      7'b0110011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1;
        operand_1_d = rs1_dout_i; operand_2_d = rs2_dout_i;
        if (funct7 == 7'b0000001 && funct3 == 3'b000) alu_opcode_d = OP_MUL;
        else if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  alu_opcode_d = OP_ADD;
            3'b001:  alu_opcode_d = OP_SLL;
            3'b010:  alu_opcode_d = OP_SLT;
            3'b111:  alu_opcode_d = OP_AND;
            default: dec_illegal = 1'b1;
          endcase
        end else dec_illegal = 1'b1;
      end
      7'b0010011: begin
        dec_illegal = (funct3 != 3'b000);
        alu_opcode_d = OP_ADD; use_rs1 = 1'b1; wr_rd = 1'b1;
        operand_1_d = rs1_dout_i; operand_2_d = imm_i;
      end
      7'b0000011: begin
        dec_illegal = (funct3 != 3'b010);
        alu_opcode_d = OP_ADD; use_rs1 = 1'b1; wr_rd = 1'b1;
        mem_ren_d = 1'b1; wb_sel_d = 1'b1;
        operand_1_d = rs1_dout_i; operand_2_d = imm_i;
      end
      7'b0100011: begin
        dec_illegal = (funct3 != 3'b010);
        alu_opcode_d = OP_ADD; use_rs1 = 1'b1; use_rs2 = 1'b1;
        mem_wen_d = 1'b1; mem_din_d = rs2_dout_i;
        operand_1_d = rs1_dout_i; operand_2_d = imm_s;
      end
      7'b1100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; branch_en_d = 1'b1; branch_offset_d = imm_b;
        operand_1_d = rs1_dout_i; operand_2_d = rs2_dout_i;
        if (funct3 == 3'b001) alu_opcode_d = OP_BNE;
        else if (funct3 == 3'b100) alu_opcode_d = OP_BLT;
        else dec_illegal = 1'b1;
      end
      7'b0110111: begin
        alu_opcode_d = OP_LUI; wr_rd = 1'b1; operand_2_d = imm_u;
      end
      7'b0010111: begin
        alu_opcode_d = OP_AUIPC; wr_rd = 1'b1;
        operand_1_d = REG_DW'(pc_i); operand_2_d = imm_u;
      end
      7'b1101111: begin
        alu_opcode_d = OP_JAL; wr_rd = 1'b1; jump_en_d = 1'b1; jump_offset_d = imm_j;
        operand_1_d = REG_DW'(pc_i); operand_2_d = REG_DW'(4);
      end
      default: dec_illegal = 1'b1;
    endcase
    // Unsupported encodings still occupy the slot so EX can trap, but do nothing.
    if (dec_illegal) begin
      alu_opcode_d = OP_NOP;  operand_1_d = '0;     operand_2_d = '0;
      mem_din_d = '0;         branch_en_d = 1'b0;   branch_offset_d = '0;
      jump_en_d = 1'b0;       jump_offset_d = '0;   mem_ren_d = 1'b0;
      mem_wen_d = 1'b0;       wb_sel_d = 1'b0;      wr_rd = 1'b0;
      use_rs1 = 1'b0;         use_rs2 = 1'b0;
    end
  end

  logic                ex_valid_q, ex_valid_d;
  logic [INST_AW-1:0]  ex_pc_q, branch_offset_q, jump_offset_q;
  logic [ALUOP_DW-1:0] alu_opcode_q;
  logic [REG_DW-1:0]   operand_1_q, operand_2_q, mem_din_q;
  logic                branch_en_q, jump_en_q, mem_ren_q, mem_wen_q;
  logic                wb_en_q, wb_sel_q, illegal_q;
  logic [REG_AW-1:0]   wb_addr_q;
  logic                hazard, if_fire;

  assign rs1_en_o   = if_valid_i & use_rs1;
  assign rs2_en_o   = if_valid_i & use_rs2;
  assign rs1_addr_o = use_rs1 ? REG_AW'(rs1) : '0;
  assign rs2_addr_o = use_rs2 ? REG_AW'(rs2) : '0;

  // A load in the slot cannot supply its result yet; hold the consumer one cycle.
  assign hazard = ex_valid_q & mem_ren_q & (wb_addr_q != '0)
                & ((rs1_en_o & (rs1_addr_o == wb_addr_q)) | (rs2_en_o & (rs2_addr_o == wb_addr_q)));
  assign if_ready_o = ~flush_i & ~hazard & (~ex_valid_q | ex_ready_i);
  assign if_fire    = if_valid_i & if_ready_o;

  always_comb begin
    ex_valid_d = ex_valid_q;
    if (flush_i)         ex_valid_d = 1'b0;
    else if (if_fire)    ex_valid_d = 1'b1;
    else if (ex_ready_i) ex_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;  ex_pc_q <= '0;        alu_opcode_q <= OP_NOP;
      operand_1_q <= '0;   operand_2_q <= '0;    branch_en_q <= 1'b0;
      branch_offset_q <= '0; jump_en_q <= 1'b0;  jump_offset_q <= '0;
      mem_ren_q <= 1'b0;   mem_wen_q <= 1'b0;    mem_din_q <= '0;
      wb_en_q <= 1'b0;     wb_sel_q <= 1'b0;     wb_addr_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (if_fire) begin
        ex_pc_q <= pc_i;               alu_opcode_q <= alu_opcode_d;
        operand_1_q <= operand_1_d;    operand_2_q <= operand_2_d;
        branch_en_q <= branch_en_d;    branch_offset_q <= branch_offset_d;
        jump_en_q <= jump_en_d;        jump_offset_q <= jump_offset_d;
        mem_ren_q <= mem_ren_d;        mem_wen_q <= mem_wen_d;
        mem_din_q <= mem_din_d;        wb_sel_q <= wb_sel_d;
        wb_en_q <= wr_rd & (rd != 5'd0);
        wb_addr_q <= wr_rd ? REG_AW'(rd) : '0;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign ex_valid_o      = ex_valid_q;
  assign ex_pc_o         = ex_pc_q;
  assign alu_opcode_o    = alu_opcode_q;
  assign operand_1_o     = operand_1_q;
  assign operand_2_o     = operand_2_q;
  assign branch_en_o     = branch_en_q;
  assign branch_offset_o = branch_offset_q;
  assign jump_en_o       = jump_en_q;
  assign jump_offset_o   = jump_offset_q;
  assign mem_ren_o       = mem_ren_q;
  assign mem_wen_o       = mem_wen_q;
  assign mem_din_o       = mem_din_q;
  assign wb_en_o         = wb_en_q;
  assign wb_sel_o        = wb_sel_q;
  assign wb_addr_o       = wb_addr_q;
  assign illegal_o       = illegal_q;

endmodule
